// File: rtl/key_step_controller.sv
// rtl/key_step_controller.sv - debounced two-key up/down stepper with auto-repeat and arbitration
module key_step_controller #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             key_inc_n,
    input  logic             key_dec_n,
    output logic [WIDTH-1:0] number,
    output logic             odd,
    output logic             step_pulse,
    output logic             dir
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Periods below 2 would make step pulses abut, so they are stretched to 2.
    localparam int  HOLD_EFF  = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
    localparam int  REP_EFF   = (REPEAT_CYCLES < 2) ? 2 : REPEAT_CYCLES;
    localparam int  RP_MAX    = (HOLD_EFF > REP_EFF) ? HOLD_EFF : REP_EFF;
    localparam int  RP_W      = $clog2(RP_MAX + 1);
    localparam bit  REPEAT_EN = (REPEAT_CYCLES > 0);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_EFF - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REP_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INC_HELD = 2'd1,
        S_DEC_HELD = 2'd2,
        S_LOCK     = 2'd3
    } state_t;

    // Bit 0 tracks the increment key, bit 1 the decrement key; all levels active-low.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db_n;
    logic [1:0]      r_db_n_d;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t          r_state;
    state_t          w_next;
    logic [RP_W-1:0] r_rp_cnt;
    logic            r_rp_phase;

    logic            w_inc_down;
    logic            w_dec_down;
    logic            w_inc_press;
    logic            w_dec_press;
    logic            w_held;
    logic            w_repeat_fire;
    logic            w_step_inc;
    logic            w_step_dec;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1     <= 2'b11;
            r_sync2     <= 2'b11;
            r_db_n      <= 2'b11;
            r_db_n_d    <= 2'b11;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1  <= {key_dec_n, key_inc_n};
            r_sync2  <= r_sync1;
            r_db_n_d <= r_db_n;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db_n[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_n[i]   <= ~r_db_n[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_inc_down  = ~r_db_n[0];
    assign w_dec_down  = ~r_db_n[1];
    assign w_inc_press = ~r_db_n[0] & r_db_n_d[0];
    assign w_dec_press = ~r_db_n[1] & r_db_n_d[1];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_inc_press && w_dec_press) begin
                    w_next = S_LOCK;
                end else if (w_inc_press) begin
                    w_next = S_INC_HELD;
                end else if (w_dec_press) begin
                    w_next = S_DEC_HELD;
                end
            end
            S_INC_HELD: begin
                if (w_dec_press) begin
                    w_next = S_LOCK;
                end else if (!w_inc_down) begin
                    w_next = S_IDLE;
                end
            end
            S_DEC_HELD: begin
                if (w_inc_press) begin
                    w_next = S_LOCK;
                end else if (!w_dec_down) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                if (!w_inc_down && !w_dec_down) begin
                    w_next = S_IDLE;
                end
            end
        endcase
    end

    assign w_held        = (r_state == S_INC_HELD) || (r_state == S_DEC_HELD);
    assign w_repeat_fire = REPEAT_EN && w_held &&
                           (r_rp_cnt == (r_rp_phase ? REP_LAST : HOLD_LAST));

    always_comb begin
        w_step_inc = 1'b0;
        w_step_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_step_inc = w_inc_press & ~w_dec_press;
                w_step_dec = w_dec_press & ~w_inc_press;
            end
            S_INC_HELD: w_step_inc = w_repeat_fire && (w_next == S_INC_HELD);
            S_DEC_HELD: w_step_dec = w_repeat_fire && (w_next == S_DEC_HELD);
            default: begin
                w_step_inc = 1'b0;
                w_step_dec = 1'b0;
            end
        endcase
    end

    // Phase 0 times the first repeat after the press step, phase 1 the later ones.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rp_cnt   <= '0;
            r_rp_phase <= 1'b0;
        end else if (w_next != r_state || !w_held || !REPEAT_EN) begin
            r_rp_cnt   <= '0;
            r_rp_phase <= 1'b0;
        end else if (w_repeat_fire) begin
            r_rp_cnt   <= '0;
            r_rp_phase <= 1'b1;
        end else begin
            r_rp_cnt   <= r_rp_cnt + RP_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            number     <= '0;
            step_pulse <= 1'b0;
            dir        <= 1'b0;
        end else begin
            step_pulse <= w_step_inc | w_step_dec;
            if (w_step_inc) begin
                number <= number + WIDTH'(1);
                dir    <= 1'b1;
            end else if (w_step_dec) begin
                number <= number - WIDTH'(1);
                dir    <= 1'b0;
            end
        end
    end

    assign odd = number[0];

endmodule

// File: tb/tb_key_step_controller.sv
// tb/tb_key_step_controller.sv - scoreboard bench for key_step_controller
module tb_key_step_controller;

    logic       clk;
    logic       rst_n;
    logic       key_inc_n;
    logic       key_dec_n;
    logic [1:0] number;
    logic       odd;
    logic       step_pulse;
    logic       dir;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int k;
    logic [1:0] exp_num = 2'd0;

    typedef struct {
        logic [1:0] num;
        logic       up;
        int         at;
    } exp_t;

    exp_t sb_q[$];

    key_step_controller #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(10),
        .REPEAT_CYCLES(5)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .key_inc_n(key_inc_n),
        .key_dec_n(key_dec_n),
        .number(number),
        .odd(odd),
        .step_pulse(step_pulse),
        .dir(dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic exp_step(input int at, input bit up);
        exp_t e;
        exp_num = up ? exp_num + 2'd1 : exp_num - 2'd1;
        e.num = exp_num;
        e.up  = up;
        e.at  = at;
        sb_q.push_back(e);
    endtask

    task automatic clean_press(input bit up);
        k = cyc + 1;
        if (up) key_inc_n = 1'b0;
        else    key_dec_n = 1'b0;
        exp_step(k + 6, up);
        tick(8);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(12);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_number"}, int'(number), 0);
        chk({tag, "_odd"}, int'(odd), 0);
        chk({tag, "_step_pulse"}, int'(step_pulse), 0);
        chk({tag, "_dir"}, int'(dir), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && step_pulse) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step: number=%0d dir=%0d at edge %0d, none expected",
                         number, dir, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (number !== e.num || dir !== e.up || odd !== e.num[0] || cyc != e.at) begin
                    errors++;
                    $display("FAIL step: got number=%0d dir=%0d odd=%0d edge=%0d, expected number=%0d dir=%0d odd=%0d edge=%0d",
                             number, dir, odd, cyc, e.num, e.up, e.num[0], e.at);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        #1;
        check_reset_outputs("reset");
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Single clean press, then bounce that never settles, then a bouncy release.
        clean_press(1'b1);
        k = cyc + 1;
        key_inc_n = 1'b0; tick(3);
        key_inc_n = 1'b1; tick(1);
        key_inc_n = 1'b0; tick(3);
        key_inc_n = 1'b1; tick(12);
        k = cyc + 1;
        key_inc_n = 1'b0;
        exp_step(k + 6, 1'b1);
        tick(5);
        key_inc_n = 1'b1; tick(3);
        key_inc_n = 1'b0; tick(1);
        key_inc_n = 1'b1; tick(12);

        // Mid-run reset clears the count of 2.
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
        exp_num = 2'd0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 4; i++) clean_press(1'b0);
        for (int i = 0; i < 4; i++) clean_press(1'b1);

        // Auto-repeat over a 40-cycle hold.
        k = cyc + 1;
        key_inc_n = 1'b0;
        exp_step(k + 6, 1'b1);
        for (int i = 0; i < 6; i++) exp_step(k + 16 + 5 * i, 1'b1);
        tick(40);
        key_inc_n = 1'b1;
        tick(20);

        // Simultaneous press locks out; re-pressing inc while dec held stays locked.
        k = cyc + 1;
        key_inc_n = 1'b0;
        key_dec_n = 1'b0;
        tick(8);
        key_inc_n = 1'b1; tick(10);
        key_inc_n = 1'b0; tick(8);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(12);

        // Dec pressed while inc held: no dec step and inc repeats stop.
        k = cyc + 1;
        key_inc_n = 1'b0;
        exp_step(k + 6, 1'b1);
        tick(7);
        key_dec_n = 1'b0;
        tick(33);
        key_inc_n = 1'b1;
        key_dec_n = 1'b1;
        tick(12);
        clean_press(1'b1);

        // Reset between edges while inc held at number 2, release with inc still held.
        k = cyc + 1;
        key_inc_n = 1'b0;
        exp_step(k + 6, 1'b1);
        tick(9);
        chk("pre_reset_number", int'(number), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_hold");
        exp_num = 2'd0;
        tick(3);
        rst_n = 1'b1;
        k = cyc + 1;
        exp_step(k + 6, 1'b1);
        tick(10);
        key_inc_n = 1'b1;
        tick(15);

        chk("pending_steps", sb_q.size(), 0);
        chk("final_number", int'(number), int'(exp_num));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
